// File: rtl/ok8_note_pkg.sv
// Shared OK-8 note definitions: the 4th-octave half-period table and decoder states.
// The melody player and the tone decoder read the same table.
package ok8_note_pkg;

  localparam int NOTE_COUNT = 6;
  localparam int NOTE_W     = 8;

  // Half-periods in clk12 cycles; entry 0 is the silence slot and never matches.
  localparam int unsigned HALF_PERIOD [0:NOTE_COUNT-1] = '{0, 22900, 20408, 18182, 17192, 15306};

  typedef enum logic [1:0] {
    SILENT,
    MEASURE,
    CANDIDATE,
    LOCKED
  } tone_state_e;

endpackage

// File: rtl/ok8_edge_sync.sv
// Two-flop synchronizer for the raw tone input plus a registered any-edge strobe.
module ok8_edge_sync (
  input  logic clk12,
  input  logic n_reset,
  input  logic tone_in,
  output logic edge_stb
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic last_q, last_d;
  logic edge_q, edge_d;

  always_comb begin
    sync1_d = tone_in;
    sync2_d = sync1_q;
    last_d  = sync2_q;
    edge_d  = sync2_q ^ last_q;
  end

  always_ff @(posedge clk12 or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      last_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      last_q  <= last_d;
      edge_q  <= edge_d;
    end
  end

  assign edge_stb = edge_q;

endmodule

// File: rtl/ok8_tone_decoder.sv
// Recovers the OK-8 note index from the speaker square wave by timing its half-period
// and requiring two consecutive matching half-periods before reporting a change.
module ok8_tone_decoder
  import ok8_note_pkg::*;
#(
  parameter int          TOL         = 256,
  parameter int          SILENCE_CYC = 40000,
  parameter int          CNT_W       = 16,
  // Right-shift applied to the note table, for a clock slower than 12 MHz.
  parameter int unsigned TBL_SHIFT   = 0
) (
  input  logic       clk12,
  input  logic       n_reset,
  input  logic       tone_in,
  output logic [7:0] note,
  output logic       note_valid,
  output logic       locked
);

  logic                edge_stb;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W:0]      hp;
  logic [NOTE_W-1:0]   k;
  logic                timeout;
  tone_state_e         state_q, state_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [NOTE_W-1:0]   cand_q, cand_d;
  logic                note_valid_q, note_valid_d;

  ok8_edge_sync u_edge_sync (
    .clk12    (clk12),
    .n_reset  (n_reset),
    .tone_in  (tone_in),
    .edge_stb (edge_stb)
  );

  // Wrap-free for any hp the counter can produce: the signed range covers the whole spread.
  function automatic logic hp_in_tol(input logic [CNT_W:0] hp_v, input int unsigned ref_cyc);
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]        mag;
    diff = $signed(hp_v - (CNT_W+1)'(ref_cyc >> TBL_SHIFT));
    mag  = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    return mag <= (CNT_W+1)'(TOL);
  endfunction

  always_comb begin
    hp      = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
    timeout = (cnt_q == CNT_W'(SILENCE_CYC - 1));
    k       = '0;
    // Descending scan so the lowest matching index is the one left in k.
    for (int i = NOTE_COUNT - 1; i >= 1; i--) begin
      if (hp_in_tol(hp, HALF_PERIOD[i])) k = NOTE_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    cand_d  = cand_q;
    if (edge_stb)      cnt_d = '0;
    else if (&cnt_q)   cnt_d = cnt_q;
    else               cnt_d = cnt_q + CNT_W'(1);

    if (timeout) begin
      // A coincident edge restarts measurement as if it were the first edge.
      state_d = edge_stb ? MEASURE : SILENT;
      note_d  = '0;
    end else if (edge_stb) begin
      case (state_q)
        SILENT:  state_d = MEASURE;
        MEASURE: begin
          if (k != '0) begin
            state_d = CANDIDATE;
            cand_d  = k;
          end
        end
        CANDIDATE: begin
          if (k == '0) begin
            state_d = MEASURE;
          end else if (k == cand_q) begin
            state_d = LOCKED;
            note_d  = cand_q;
          end else begin
            cand_d = k;
          end
        end
        LOCKED: begin
          if (k != note_q) begin
            if (k != '0) begin
              state_d = CANDIDATE;
              cand_d  = k;
            end else begin
              state_d = MEASURE;
            end
          end
        end
        default: state_d = SILENT;
      endcase
    end
    note_valid_d = (note_d != note_q);
  end

  always_ff @(posedge clk12 or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= SILENT;
      cnt_q        <= '0;
      note_q       <= '0;
      cand_q       <= '0;
      note_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      note_q       <= note_d;
      cand_q       <= cand_d;
      note_valid_q <= note_valid_d;
    end
  end

  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign locked     = (state_q == LOCKED);

endmodule
